fifo_frame_writer: RTL and testbench

Write-side producer for the dual-clock feature-map FIFO. Accepts a valid/ready word stream from the convolution datapath in the wr_clk domain, frames it by a start-of-frame marker and a programmed word count, and drives the FIFO write port (din/wr_en) while never issuing a write against full. Sits between the layer output stage and the FIFO's write port; the FIFO read side is consumed in rd_clk.

---
 rtl/fifo_frame_pkg.sv | 16 +
 rtl/skid_buf2.sv | 60 ++++++
 rtl/fifo_frame_writer.sv | 134 +++++++++++++
 tb/tb_fifo_frame_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_pkg.sv
// Shared types and widths for the feature-map FIFO write-side framer.
package fifo_frame_pkg;

    localparam int unsigned DW_DEF = 12;
    localparam int unsigned LW_DEF = 16;
    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer: in-order push/pop, head is the oldest entry.
module skid_buf2 #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_pop;
    logic         do_push;
    logic [1:0]   slot;

    assign do_pop  = pop && (occ_q != 2'd0);
    assign do_push = push && (occ_q != 2'd2);

    // Pop shifts entry 1 into the head; push lands in the first free slot after that.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        slot  = occ_q;
        if (do_pop) begin
            e0_d  = e1_q;
            occ_d = 2'(occ_q - 2'd1);
            slot  = 2'(occ_q - 2'd1);
        end
        if (do_push) begin
            if (slot == 2'd0) begin
                e0_d = din;
            end else begin
                e1_d = din;
            end
            occ_d = 2'(occ_d + 2'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_frame_writer.sv
// Frames an upstream word stream by SOF and programmed length and drives the FIFO write port.
module fifo_frame_writer
    import fifo_frame_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned LW = LW_DEF
) (
    input  logic              wr_clk,
    input  logic              fifo_rst,
    input  logic              start,
    input  logic [LW-1:0]     cfg_frame_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_sof,
    output logic [DW-1:0]     fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    input  logic              fifo_wr_rst_busy,
    output logic              busy,
    output logic              done,
    output logic [LW-1:0]     word_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              err_sof
);

    state_e            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     word_cnt_q, word_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              err_sof_q, err_sof_d;

    logic [1:0]        occ;
    logic [DW:0]       head;
    logic              has_head;
    logic              head_sof;
    logic [DW-1:0]     head_data;
    logic              push;
    logic              pop;
    logic              wr_go;
    logic              discard;
    logic [LW-1:0]     cnt_inc;

    assign has_head  = (occ != 2'd0);
    assign head_sof  = head[DW];
    assign head_data = head[DW-1:0];
    assign s_ready   = (occ != 2'd2) && !fifo_wr_rst_busy && !fifo_rst;
    assign push      = s_valid && s_ready;
    // Write gating looks at full in the same cycle so no write is ever issued against full.
    assign wr_go     = (state_q == STREAM) && has_head && !fifo_full && !fifo_wr_rst_busy;
    assign discard   = (state_q == WAIT_SOF) && has_head && !head_sof;
    assign pop       = wr_go || discard;
    assign cnt_inc   = LW'(word_cnt_q + LW'(1));

    skid_buf2 #(.W(DW + 1)) u_buf (
        .clk  (wr_clk),
        .rst  (fifo_rst),
        .push (push),
        .pop  (pop),
        .din  ({s_sof, s_data}),
        .head (head),
        .occ  (occ)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_sof_d  = err_sof_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    word_cnt_d = '0;
                    drop_cnt_d = '0;
                    err_sof_d  = 1'b0;
                    if (cfg_frame_len != '0) begin
                        len_d   = cfg_frame_len;
                        state_d = WAIT_SOF;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_SOF: begin
                if (has_head && head_sof) begin
                    state_d = STREAM;
                end else if (discard && (drop_cnt_q != DROP_MAX)) begin
                    drop_cnt_d = DROP_W'(drop_cnt_q + DROP_W'(1));
                end
            end
            STREAM: begin
                if (wr_go) begin
                    word_cnt_d = cnt_inc;
                    // Only the word written at count 0 may legitimately carry SOF.
                    if (head_sof && (word_cnt_q != '0)) begin
                        err_sof_d = 1'b1;
                    end
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
            err_sof_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_sof_q  <= err_sof_d;
        end
    end

    assign fifo_wr_en = wr_go;
    assign fifo_din   = wr_go ? head_data : '0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign word_cnt   = word_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign err_sof    = err_sof_q;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Self-checking bench for fifo_frame_writer: queue-based reference model plus directed literal checks.
module tb_fifo_frame_writer;

    localparam int unsigned DW = 12;
    localparam int unsigned LW = 16;
    localparam int P_IDLE = 0, P_WAIT = 1, P_STREAM = 2, P_DONE = 3;

    logic          wr_clk = 1'b0;
    logic          fifo_rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_frame_len = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_sof = 1'b0;
    logic [DW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_rst_busy = 1'b0;
    logic          busy;
    logic          done;
    logic [LW-1:0] word_cnt;
    logic [7:0]    drop_cnt;
    logic          err_sof;

    fifo_frame_writer #(.DW(DW), .LW(LW)) dut (
        .wr_clk           (wr_clk),
        .fifo_rst         (fifo_rst),
        .start            (start),
        .cfg_frame_len    (cfg_frame_len),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_sof            (s_sof),
        .fifo_din         (fifo_din),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_full        (fifo_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy),
        .busy             (busy),
        .done             (done),
        .word_cnt         (word_cnt),
        .drop_cnt         (drop_cnt),
        .err_sof          (err_sof)
    );

    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: buffer contents as a queue, frame phase, counters.
    logic [DW:0]   mq[$];
    int            m_phase, m_len, m_wcnt, m_drop;
    bit            m_err;

    // Stimulus and observation state.
    logic [DW:0]   src[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] wr_log[$];
    int            wr_cyc[$];
    int            vpct = 100, fpct = 0;
    bit            full_force = 1'b1, full_val = 1'b0;
    int            cyc = 0, done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = P_IDLE;
        m_len   = 0;
        m_wcnt  = 0;
        m_drop  = 0;
        m_err   = 1'b0;
    endtask

    task automatic compare_outputs();
        bit exp_ready, exp_wr;
        exp_ready = (mq.size() < 2) && !fifo_wr_rst_busy && !fifo_rst;
        exp_wr    = !fifo_rst && (m_phase == P_STREAM) && (mq.size() > 0) && !fifo_full && !fifo_wr_rst_busy;
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        if (exp_wr) chk("fifo_din", 32'(fifo_din), 32'(mq[0][DW-1:0]));
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("done", 32'(done), 32'(m_phase == P_DONE));
        chk("word_cnt", 32'(word_cnt), 32'(m_wcnt));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("err_sof", 32'(err_sof), 32'(m_err));
        if (fifo_wr_en === 1'b1) begin
            wr_log.push_back(fifo_din);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_seen++;
    endtask

    task automatic model_edge();
        logic [DW:0] w;
        bit rdy, push, wr;
        if (fifo_rst) begin
            model_reset();
            return;
        end
        rdy  = (mq.size() < 2) && !fifo_wr_rst_busy;
        push = s_valid && rdy;
        wr   = (m_phase == P_STREAM) && (mq.size() > 0) && !fifo_full && !fifo_wr_rst_busy;
        case (m_phase)
            P_IDLE: if (start) begin
                m_wcnt = 0;
                m_drop = 0;
                m_err  = 1'b0;
                if (cfg_frame_len != '0) begin
                    m_len   = int'(cfg_frame_len);
                    m_phase = P_WAIT;
                end else begin
                    m_phase = P_DONE;
                end
            end
            P_WAIT: if (mq.size() > 0) begin
                if (mq[0][DW]) m_phase = P_STREAM;
                else begin
                    void'(mq.pop_front());
                    if (m_drop < 255) m_drop++;
                end
            end
            P_STREAM: if (wr) begin
                w = mq.pop_front();
                if (w[DW] && m_wcnt != 0) m_err = 1'b1;
                m_wcnt++;
                if (m_wcnt == m_len) m_phase = P_DONE;
            end
            default: m_phase = P_IDLE;
        endcase
        if (push) begin
            mq.push_back({s_sof, s_data});
            void'(src.pop_front());
        end
    endtask

    task automatic tick();
        @(negedge wr_clk);
        compare_outputs();
        @(posedge wr_clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic set_inputs();
        logic [DW:0] h;
        if (src.size() > 0 && int'($urandom_range(99)) < vpct) begin
            h       = src[0];
            s_valid = 1'b1;
            s_sof   = h[DW];
            s_data  = h[DW-1:0];
        end else begin
            s_valid = 1'b0;
            s_sof   = 1'($urandom_range(1));
            s_data  = DW'($urandom);
        end
        fifo_full = full_force ? full_val : (int'($urandom_range(99)) < fpct);
    endtask

    task automatic pulse_start(input int len);
        start         = 1'b1;
        cfg_frame_len = LW'(len);
        set_inputs();
        tick();
        start         = 1'b0;
        cfg_frame_len = LW'($urandom);
    endtask

    task automatic add_frame(input int len, input int junk, input int mid_sof, input int extra);
        logic [DW-1:0] d;
        exp_data.delete();
        for (int i = 0; i < junk; i++) src.push_back({1'b0, DW'($urandom)});
        for (int i = 0; i < len; i++) begin
            d = DW'($urandom);
            src.push_back({1'((i == 0) || (i == mid_sof)), d});
            exp_data.push_back(d);
        end
        for (int i = 0; i < extra; i++) src.push_back({1'b0, DW'($urandom)});
    endtask

    task automatic hard_reset();
        fifo_rst = 1'b1;
        model_reset();
        src.delete();
        tick();
        tick();
        fifo_rst = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int k = 0;
        while (m_phase != P_IDLE && k < budget) begin
            set_inputs();
            tick();
            k++;
        end
        if (m_phase != P_IDLE) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout at cycle %0d: still busy after %0d cycles, required idle", cyc, budget);
            hard_reset();
        end
    endtask

    task automatic run_until_writes(input int n, input int budget);
        int k = 0;
        while (wr_log.size() < n && k < budget) begin
            set_inputs();
            tick();
            k++;
        end
        if (wr_log.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout at cycle %0d: got %0d writes, required %0d", cyc, wr_log.size(), n);
        end
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_count"}, 32'(wr_log.size()), 32'(exp_data.size()));
        for (int i = 0; i < wr_log.size() && i < exp_data.size(); i++)
            chk({nm, "_data"}, 32'(wr_log[i]), 32'(exp_data[i]));
    endtask

    task automatic check_all_reset(input string nm);
        chk({nm, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({nm, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({nm, "_din"}, 32'(fifo_din), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_word_cnt"}, 32'(word_cnt), 32'd0);
        chk({nm, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({nm, "_err_sof"}, 32'(err_sof), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, len, junk, mid, extra;
        model_reset();
        #2 fifo_rst = 1'b1;
        #1;
        check_all_reset("por");
        tick();
        tick();
        fifo_rst = 1'b0;

        // Zero-length frame: done the cycle after start, no writes; start during DONE is ignored.
        wr_log.delete();
        pulse_start(0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd1);
        start = 1'b1;
        cfg_frame_len = LW'(7);
        set_inputs();
        tick();
        start = 1'b0;
        chk("len0_start_ignored_busy", 32'(busy), 32'd0);
        chk("len0_writes", 32'(wr_log.size()), 32'd0);

        // len=4 back-to-back, with a second start while armed that must not change the length.
        full_force = 1'b1; full_val = 1'b0; vpct = 100;
        wr_log.delete(); wr_cyc.delete(); d0 = done_seen;
        pulse_start(4);
        start = 1'b1; cfg_frame_len = LW'(9); set_inputs(); tick(); start = 1'b0;
        add_frame(4, 0, -1, 0);
        run_to_idle(200);
        check_log("t1");
        if (wr_cyc.size() == 4) chk("t1_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
        chk("t1_word_cnt", 32'(word_cnt), 32'd4);
        chk("t1_done_pulses", 32'(done_seen - d0), 32'd1);

        // len=8 after 3 non-SOF words.
        wr_log.delete();
        pulse_start(8);
        add_frame(8, 3, -1, 0);
        run_to_idle(200);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd3);
        check_log("t2");

        // len=6 with a 5-cycle full stall and a short wr_rst_busy window mid-frame.
        wr_log.delete();
        pulse_start(6);
        add_frame(6, 0, -1, 0);
        run_until_writes(2, 100);
        full_val = 1'b1;
        n0 = wr_log.size();
        repeat (5) begin set_inputs(); tick(); end
        chk("t3_stall_writes", 32'(wr_log.size()), 32'(n0));
        chk("t3_s_ready_low", 32'(s_ready), 32'd0);
        full_val = 1'b0;
        fifo_wr_rst_busy = 1'b1;
        repeat (2) begin set_inputs(); tick(); end
        chk("t3_rst_busy_writes", 32'(wr_log.size()), 32'(n0));
        fifo_wr_rst_busy = 1'b0;
        run_to_idle(200);
        check_log("t3");

        // len=5 with SOF repeated on the 3rd word.
        wr_log.delete(); d0 = done_seen;
        pulse_start(5);
        add_frame(5, 0, 2, 0);
        run_to_idle(200);
        chk("t4_err_sof", 32'(err_sof), 32'd1);
        chk("t4_done_pulses", 32'(done_seen - d0), 32'd1);
        check_log("t4");

        // Next start clears err_sof; reset after 2 of 10 words abandons the frame.
        wr_log.delete();
        pulse_start(10);
        chk("t5_err_cleared", 32'(err_sof), 32'd0);
        add_frame(10, 0, -1, 0);
        run_until_writes(2, 100);
        d0 = done_seen;
        fifo_rst = 1'b1;
        model_reset();
        src.delete();
        #1;
        check_all_reset("t5_rst");
        tick();
        tick();
        fifo_rst = 1'b0;
        chk("t5_no_done", 32'(done_seen - d0), 32'd0);
        wr_log.delete(); d0 = done_seen;
        pulse_start(2);
        add_frame(2, 0, -1, 0);
        run_to_idle(200);
        check_log("t5b");
        chk("t5b_word_cnt", 32'(word_cnt), 32'd2);
        chk("t5b_done_pulses", 32'(done_seen - d0), 32'd1);

        // drop_cnt saturation.
        wr_log.delete();
        pulse_start(1);
        add_frame(1, 260, -1, 0);
        run_to_idle(1500);
        chk("t6_drop_sat", 32'(drop_cnt), 32'd255);
        check_log("t6");

        // Randomised frames: leftovers, junk, stalls, occasional repeated SOF.
        full_force = 1'b0;
        for (int f = 0; f < 40; f++) begin
            len   = int'($urandom_range(1, 12));
            junk  = int'($urandom_range(0, 3));
            mid   = (len > 1 && $urandom_range(9) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            extra = int'($urandom_range(0, 2));
            vpct  = int'($urandom_range(40, 100));
            fpct  = int'($urandom_range(0, 40));
            repeat (int'($urandom_range(0, 3))) begin set_inputs(); tick(); end
            wr_log.delete();
            pulse_start(len);
            add_frame(len, junk, mid, extra);
            run_to_idle(2000);
            check_log("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
